// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall FSM with branch-flush priority and saturating perf counters
module hazard_stall_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  IDEX_MemRead,
   input  logic [REG_ADDR_W-1:0] IDEX_rd,
   input  logic [REG_ADDR_W-1:0] IFID_rs1,
   input  logic [REG_ADDR_W-1:0] IFID_rs2,
   input  logic                  IFID_uses_rs1,
   input  logic                  IFID_uses_rs2,
   input  logic                  branch_taken,
   output logic                  PC_write,
   output logic                  IFID_Write,
   output logic                  IDEX_control_mux,
   output logic                  IFID_flush,
   output logic                  stall_active,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   // Remaining-cycle counter reloads with LOAD_LATENCY-1 because the
   // detection cycle itself is the first stall cycle.
   localparam logic [3:0] RELOAD = 4'(LOAD_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic       hazard;

   // Load-use match; x0 never carries a real dependency.
   always_comb begin
      hazard = IDEX_MemRead && (IDEX_rd != '0) &&
               ((IFID_uses_rs1 && (IDEX_rd == IFID_rs1)) ||
                (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));
   end

   // Next-state and pipeline-control outputs; a taken branch outranks any stall.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      PC_write         = 1'b1;
      IFID_Write       = 1'b1;
      IDEX_control_mux = 1'b1;
      IFID_flush       = 1'b0;
      case (state)
         IDLE: begin
            if (branch_taken) begin
               IFID_flush       = 1'b1;
               IDEX_control_mux = 1'b0;
            end else if (hazard) begin
               PC_write         = 1'b0;
               IFID_Write       = 1'b0;
               IDEX_control_mux = 1'b0;
               if (LOAD_LATENCY > 1) begin
                  state_next = STALL;
                  cnt_next   = RELOAD;
               end
            end
         end
         STALL: begin
            if (branch_taken) begin
               IFID_flush       = 1'b1;
               IDEX_control_mux = 1'b0;
               state_next       = IDLE;
               cnt_next         = 4'd0;
            end else begin
               PC_write         = 1'b0;
               IFID_Write       = 1'b0;
               IDEX_control_mux = 1'b0;
               cnt_next         = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // FSM state and remaining-stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Saturating performance counters; they stick at all-ones rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!PC_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (IFID_flush && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

   assign stall_active = (state == STALL);

endmodule
